mc_sequencer: RTL and testbench

//  Multi-cycle control FSM; sequences the CPU datapath through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mc_sequencer_pkg.sv | 39 +++
 rtl/mc_sequencer_if.sv | 31 +++
 rtl/mc_perf_cnt.sv | 37 +++
 rtl/mc_sequencer.sv | 135 +++++++++++++
 tb/tb_mc_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_sequencer_pkg.sv
// ============================================================================
// Module  : mc_sequencer_pkg
// Brief   : Shared widths, command/PC-source codes and sequencer state encoding
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_sequencer_pkg;

    localparam int W_CPU      = 32;
    localparam int W_MEM_CMD  = 2;
    localparam int W_PC_SRC   = 2;
    localparam int W_MC_STATE = 3;

    localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
    localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
    localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

    localparam logic [W_PC_SRC-1:0] PC_SRC_NEXT   = 2'd0;
    localparam logic [W_PC_SRC-1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [W_PC_SRC-1:0] PC_SRC_JUMP   = 2'd2;

    // Encodings are architecturally visible on the state output.
    typedef enum logic [W_MC_STATE-1:0] {
        MC_FETCH  = 3'd0,
        MC_DECODE = 3'd1,
        MC_EXEC   = 3'd2,
        MC_MEM    = 3'd3,
        MC_WB     = 3'd4,
        MC_HALT   = 3'd5
    } mc_state_e;

    function automatic logic is_mem_op(input logic [W_MEM_CMD-1:0] cmd);
        return (cmd != MEM_NOP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_sequencer_if.sv
// ============================================================================
// Module  : mc_sequencer_if
// Brief   : Shared memory port, req/ack handshake between sequencer and memory
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_sequencer_if;

    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_sel,
        output mem_ack
    );

endinterface

`default_nettype wire

// File: rtl/mc_perf_cnt.sv
// ============================================================================
// Module  : mc_perf_cnt
// Brief   : Free-running cycle and retired-instruction counters, wrap on overflow
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_perf_cnt #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         cyc_en,
    input  wire logic         ins_en,
    output logic [W-1:0]      cyc_cnt,
    output logic [W-1:0]      ins_cnt
);

    logic [W-1:0] r_cyc_cnt;
    logic [W-1:0] r_ins_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else begin
            if (cyc_en) r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (ins_en) r_ins_cnt <= r_ins_cnt + 1'b1;
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ins_cnt = r_ins_cnt;

endmodule

`default_nettype wire

// File: rtl/mc_sequencer.sv
// ============================================================================
// Module  : mc_sequencer
// Brief   : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM sharing one memory
//           port. Define MC_PERF_EN to add cyc_cnt/ins_cnt performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int W_STATE = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [W_MEM_CMD-1:0] mem_cmd_dec,
    input  wire logic                 reg_wen_dec,
    input  wire logic [W_PC_SRC-1:0]  pc_src_dec,
    input  wire logic                 halt_dec,
    mc_sequencer_if.master            mem,
    output logic                      ir_wen,
    output logic                      pc_wen,
    output logic [W_PC_SRC-1:0]       pc_src,
    output logic                      reg_wen,
    output logic [W_STATE-1:0]        state,
    output logic                      halted
`ifdef MC_PERF_EN
    ,
    output logic [W_CPU-1:0]          cyc_cnt,
    output logic [W_CPU-1:0]          ins_cnt
`endif
);

    mc_state_e r_state;
    mc_state_e w_next;

    logic w_mem_req;
    logic w_mem_we;
    logic w_mem_sel;
    logic w_ir_wen;
    logic w_pc_wen;
    logic w_reg_wen;
    logic w_halted;

    always_ff @(posedge clk) begin
        if (rst) r_state <= MC_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_mem_sel = 1'b0;
        w_ir_wen  = 1'b0;
        w_pc_wen  = 1'b0;
        w_reg_wen = 1'b0;
        w_halted  = 1'b0;

        case (r_state)
            MC_FETCH: begin
                w_mem_req = 1'b1;
                if (mem.mem_ack) begin
                    w_ir_wen = 1'b1;
                    w_next   = MC_DECODE;
                end
            end
            MC_DECODE: begin
                w_next = halt_dec ? MC_HALT : MC_EXEC;
            end
            MC_EXEC: begin
                if (is_mem_op(mem_cmd_dec)) begin
                    w_next = MC_MEM;
                end else if (reg_wen_dec) begin
                    w_next = MC_WB;
                end else begin
                    w_pc_wen = 1'b1;
                    w_next   = MC_FETCH;
                end
            end
            MC_MEM: begin
                // Request stays up until ack; a store retires straight from here.
                w_mem_req = 1'b1;
                w_mem_sel = 1'b1;
                w_mem_we  = (mem_cmd_dec == MEM_WRITE);
                if (mem.mem_ack) begin
                    if (mem_cmd_dec == MEM_WRITE) begin
                        w_pc_wen = 1'b1;
                        w_next   = MC_FETCH;
                    end else begin
                        w_next = MC_WB;
                    end
                end
            end
            MC_WB: begin
                w_reg_wen = 1'b1;
                w_pc_wen  = 1'b1;
                w_next    = MC_FETCH;
            end
            MC_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next = MC_FETCH;
            end
        endcase
    end

    // Reset masks every strobe combinationally, even in the cycle it is first seen.
    assign mem.mem_req = w_mem_req & ~rst;
    assign mem.mem_we  = w_mem_we  & ~rst;
    assign mem.mem_sel = w_mem_sel & ~rst;
    assign ir_wen      = w_ir_wen  & ~rst;
    assign pc_wen      = w_pc_wen  & ~rst;
    assign reg_wen     = w_reg_wen & ~rst;
    assign halted      = w_halted  & ~rst;
    assign pc_src      = pc_wen ? pc_src_dec : PC_SRC_NEXT;
    assign state       = r_state;

`ifdef MC_PERF_EN
    mc_perf_cnt #(
        .W (W_CPU)
    ) u_perf_cnt (
        .clk     (clk),
        .rst     (rst),
        .cyc_en  (r_state != MC_HALT),
        .ins_en  (pc_wen),
        .cyc_cnt (cyc_cnt),
        .ins_cnt (ins_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_sequencer.sv
// ============================================================================
// Module  : tb_mc_sequencer
// Brief   : Directed vector table plus hand sequences for mc_sequencer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_sequencer;
    import mc_sequencer_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [W_MEM_CMD-1:0] mem_cmd_dec;
    logic                 reg_wen_dec;
    logic [W_PC_SRC-1:0]  pc_src_dec;
    logic                 halt_dec;
    logic                 ir_wen;
    logic                 pc_wen;
    logic [W_PC_SRC-1:0]  pc_src;
    logic                 reg_wen;
    logic [2:0]           state;
    logic                 halted;
`ifdef MC_PERF_EN
    logic [W_CPU-1:0]     cyc_cnt;
    logic [W_CPU-1:0]     ins_cnt;
`endif

    mc_sequencer_if u_mem_if ();

    mc_sequencer #(
        .W_STATE (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_cmd_dec (mem_cmd_dec),
        .reg_wen_dec (reg_wen_dec),
        .pc_src_dec  (pc_src_dec),
        .halt_dec    (halt_dec),
        .mem         (u_mem_if),
        .ir_wen      (ir_wen),
        .pc_wen      (pc_wen),
        .pc_src      (pc_src),
        .reg_wen     (reg_wen),
        .state       (state),
        .halted      (halted)
`ifdef MC_PERF_EN
        ,
        .cyc_cnt     (cyc_cnt),
        .ins_cnt     (ins_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {state, req, we, sel, ir, pcw, pc_src, rgw, halted}
    typedef struct packed {
        logic                 rst;
        logic                 ack;
        logic [W_MEM_CMD-1:0] cmd;
        logic                 rw;
        logic [W_PC_SRC-1:0]  ps;
        logic                 halt;
        logic [12:0]          exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_miss;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5;
    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;
    localparam logic [1:0] NX = 2'd0, BR = 2'd1, JP = 2'd2;

    function automatic logic [12:0] ex(input logic [2:0] st, input logic req, input logic we,
                                       input logic sel, input logic ir, input logic pcw,
                                       input logic [1:0] pcs, input logic rgw, input logic hlt);
        return {st, req, we, sel, ir, pcw, pcs, rgw, hlt};
    endfunction

    task automatic add(input logic r, input logic a, input logic [1:0] c, input logic rw,
                       input logic [1:0] ps, input logic h, input logic [12:0] e);
        vec_t v;
        v.rst = r; v.ack = a; v.cmd = c; v.rw = rw; v.ps = ps; v.halt = h; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic a, input logic [1:0] c, input logic rw,
                         input logic [1:0] ps, input logic h);
        rst = r; u_mem_if.mem_ack = a; mem_cmd_dec = c; reg_wen_dec = rw;
        pc_src_dec = ps; halt_dec = h;
    endtask

    initial begin
        logic [12:0] act;
        int          lat;
        n_vec  = 0;
        n_miss = 0;

        // Reset held 2 cycles with ack high: FETCH but no strobes
        add(1,1,NOP,1,NX,0, ex(F,0,0,0,0,0,NX,0,0));
        add(1,1,NOP,1,NX,0, ex(F,0,0,0,0,0,NX,0,0));
        // ADD with write-back, zero-wait
        add(0,1,NOP,1,NX,0, ex(F,1,0,0,1,0,NX,0,0));
        add(0,1,NOP,1,NX,0, ex(D,0,0,0,0,0,NX,0,0));
        add(0,1,NOP,1,NX,0, ex(E,0,0,0,0,0,NX,0,0));
        add(0,1,NOP,1,NX,0, ex(W,0,0,0,0,1,NX,1,0));
        // Load: 3 wait cycles in FETCH, 2 in MEM
        for (int i = 0; i < 3; i++) add(0,0,RD,1,NX,0, ex(F,1,0,0,0,0,NX,0,0));
        add(0,1,RD,1,NX,0, ex(F,1,0,0,1,0,NX,0,0));
        add(0,1,RD,1,NX,0, ex(D,0,0,0,0,0,NX,0,0));
        add(0,1,RD,1,NX,0, ex(E,0,0,0,0,0,NX,0,0));
        for (int i = 0; i < 2; i++) add(0,0,RD,1,NX,0, ex(M,1,0,1,0,0,NX,0,0));
        add(0,1,RD,1,NX,0, ex(M,1,0,1,0,0,NX,0,0));
        add(0,0,RD,1,NX,0, ex(W,0,0,0,0,1,NX,1,0));
        // Store, zero-wait
        add(0,1,WR,0,NX,0, ex(F,1,0,0,1,0,NX,0,0));
        add(0,1,WR,0,NX,0, ex(D,0,0,0,0,0,NX,0,0));
        add(0,1,WR,0,NX,0, ex(E,0,0,0,0,0,NX,0,0));
        add(0,1,WR,0,NX,0, ex(M,1,1,1,0,1,NX,0,0));
        // Branch: pc_src follows decoder only on the retire cycle
        add(0,1,NOP,0,BR,0, ex(F,1,0,0,1,0,NX,0,0));
        add(0,1,NOP,0,BR,0, ex(D,0,0,0,0,0,NX,0,0));
        add(0,1,NOP,0,BR,0, ex(E,0,0,0,0,1,BR,0,0));
        // Reset mid-MEM with ack pending
        add(0,1,RD,1,NX,0, ex(F,1,0,0,1,0,NX,0,0));
        add(0,1,RD,1,NX,0, ex(D,0,0,0,0,0,NX,0,0));
        add(0,1,RD,1,NX,0, ex(E,0,0,0,0,0,NX,0,0));
        add(0,0,RD,1,NX,0, ex(M,1,0,1,0,0,NX,0,0));
        add(1,1,RD,1,NX,0, ex(M,0,0,0,0,0,NX,0,0));
        add(0,0,NOP,0,JP,1, ex(F,1,0,0,0,0,NX,0,0));
        // Halt: stays put with ack high, exits only via reset
        add(0,1,NOP,0,JP,1, ex(F,1,0,0,1,0,NX,0,0));
        add(0,1,NOP,0,JP,1, ex(D,0,0,0,0,0,NX,0,0));
        for (int i = 0; i < 10; i++) add(0,1,RD,1,JP,0, ex(H,0,0,0,0,0,NX,0,1));
        add(1,1,RD,1,JP,0, ex(H,0,0,0,0,0,NX,0,0));
        add(0,0,NOP,0,NX,0, ex(F,1,0,0,0,0,NX,0,0));

        drive(1,0,NOP,0,NX,0);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ack, vecs[i].cmd, vecs[i].rw, vecs[i].ps, vecs[i].halt);
            #1;
            act = {state, u_mem_if.mem_req, u_mem_if.mem_we, u_mem_if.mem_sel,
                   ir_wen, pc_wen, pc_src, reg_wen, halted};
            n_vec++;
            if (act !== vecs[i].exp) begin
                n_miss++;
                $display("FAIL vec%0d {st,req,we,sel,ir,pcw,pcs,rgw,hlt} got=%b exp=%b",
                         i, act, vecs[i].exp);
            end
        end

        // ALU op with write-back: retire latency from first FETCH cycle
        @(negedge clk);
        drive(1,1,NOP,1,NX,0);
        @(negedge clk);
        drive(0,1,NOP,1,NX,0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (pc_wen) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (lat != 4) begin
            n_miss++;
            $display("FAIL alu_wb_latency got=%0d exp=4 (0 = timeout)", lat);
        end

`ifdef MC_PERF_EN
        // Three ALU ops without write-back, then a halt
        @(negedge clk);
        drive(1,1,NOP,0,NX,0);
        @(negedge clk);
        drive(0,1,NOP,0,NX,0);
        repeat (9) @(posedge clk);
        #1;
        n_vec++;
        if (cyc_cnt !== 32'd9 || ins_cnt !== 32'd3) begin
            n_miss++;
            $display("FAIL perf_3alu cyc=%0d ins=%0d exp cyc=9 ins=3", cyc_cnt, ins_cnt);
        end
        halt_dec = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_vec++;
        if (cyc_cnt !== 32'd11 || ins_cnt !== 32'd3 || halted !== 1'b1) begin
            n_miss++;
            $display("FAIL perf_halt cyc=%0d ins=%0d halted=%b exp cyc=11 ins=3 halted=1",
                     cyc_cnt, ins_cnt, halted);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
